mcse_bus_arbiter: RTL
=====================

MCSE_BUS_ARBITER -- requirements
Module: mcse_bus_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 3: number of requesters (2..8).
REQ-002 The block SHALL have parameter pAHB_ADDR_WIDTH, default 32: transaction address width.
REQ-003 The block SHALL have parameter pPAYLOAD_SIZE_BITS, default 256: payload width.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum WAIT cycles before abort (>=2).
REQ-005 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 The block SHALL have port req_go  input  NREQ  per-requester level request, held until that requester's req_done.
REQ-008 The block SHALL have port req_addr  input  NREQ*pAHB_ADDR_WIDTH  packed addresses, requester i at slice i.
REQ-009 The block SHALL have port req_write  input  NREQ*pPAYLOAD_SIZE_BITS  packed write payloads.
REQ-010 The block SHALL have port req_RW  input  NREQ  per-requester direction: 1 = write, 0 = read.
REQ-011 The block SHALL have port req_done  output  NREQ  one-hot, one-cycle completion pulse.
REQ-012 The block SHALL have port req_err  output  NREQ  one-cycle pulse coincident with req_done on timeout.
REQ-013 The block SHALL have port req_rdData  output  pPAYLOAD_SIZE_BITS  shared read data, valid while any req_done is high.
REQ-014 The block SHALL have port bus_go  output  1  one-cycle start pulse to the AHB payload engine.
REQ-015 The block SHALL have ports bus_addr / bus_write / bus_RW  output  pAHB_ADDR_WIDTH / pPAYLOAD_SIZE_BITS / 1  registered transaction fields.
REQ-016 The block SHALL have port bus_done  input  1  engine completion pulse.
REQ-017 The block SHALL have port bus_rdData  input  pPAYLOAD_SIZE_BITS  engine read data, valid with bus_done.
REQ-018 The block SHALL have ports grant_id  output  $clog2(NREQ)  and busy  output  1: current owner and not-IDLE flag.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-020 IDLE: when any req_go bit is set, the FSM SHALL select the first set bit at or after rr_ptr, modulo NREQ.
- Same edge: latch grant_id, bus_addr, bus_write and bus_RW from that slice.
- Next state: ISSUE.
REQ-021 ISSUE SHALL hold bus_go=1 for exactly one cycle, then go to WAIT.
REQ-022 WAIT SHALL clear the timeout counter on entry and increment it each cycle.
- bus_done=1: latch bus_rdData into req_rdData and go to RESP.
- Counter reaches TIMEOUT_CYCLES-1 with bus_done=0: set req_rdData to 0, set the error flag, go to RESP.
REQ-023 RESP (one cycle) SHALL pulse req_done[grant_id], plus req_err[grant_id] if the error flag is set.
- Set rr_ptr = (grant_id+1) mod NREQ, clear the error flag, go to IDLE.
REQ-024 Minimum latency: req_go sampled in IDLE at edge t -> bus_go high in cycle t+1 -> bus_done at edge d>=t+2 -> req_done high in cycle d+1 -> IDLE at d+2.
REQ-025 bus_done asserted in IDLE, ISSUE or RESP SHALL be ignored.
REQ-026 Deassertion of the granted req_go during ISSUE or WAIT SHALL NOT abort the transaction; it completes and req_done still pulses.
REQ-027 req_go changes of non-granted requesters SHALL have no effect until the next IDLE evaluation.
REQ-028 A requester still holding req_go after its req_done SHALL be re-arbitrated in the following IDLE at lowest priority.
REQ-029 bus_addr, bus_write and bus_RW SHALL stay stable from ISSUE through RESP.
REQ-030 busy SHALL be 1 in ISSUE, WAIT and RESP, and 0 in IDLE.
REQ-031 At most one bit of req_done SHALL be set in any cycle, and no more than one bus transaction SHALL be outstanding.

Reset
REQ-032 Asserting rst SHALL immediately force, independent of clk:
- state = IDLE, rr_ptr = 0, grant_id = 0, timeout counter = 0, error flag = 0;
- bus_go, bus_addr, bus_write, bus_RW, busy = 0;
- req_done, req_err, req_rdData = 0.
REQ-033 Reset mid-transaction SHALL drop it with no req_done; the engine is reset by the same rst.
REQ-034 After rst deasserts, the first arbitration SHALL occur at the first rising edge with any req_go set.

Verification
REQ-035 Single read: req_go=3'b010, req_RW[1]=0, bus_done 3 cycles after bus_go with bus_rdData=256'hA5..A5 -> one bus_go; req_done=3'b010 one cycle with req_rdData=A5..A5; grant_id=1.
REQ-036 Contention: req_go=3'b111 held; each bus_done 2 cycles after bus_go -> grants 0,1,2,0 in order; req_done pulses 001,010,100,001.
REQ-037 Timeout: TIMEOUT_CYCLES=8, req_go[2]=1, bus_done never asserted -> req_done[2] and req_err[2] high together; req_rdData=0; next grant starts at requester 0.
REQ-038 Spurious done: bus_done pulsed in IDLE and ISSUE -> ignored; a transaction still requires a bus_done during WAIT.
REQ-039 Reset in WAIT: rst asserted mid-clock -> bus_go, busy and req_done = 0 before the next edge; after release, req_go=3'b100 is granted first (rr_ptr=0 search).
REQ-040 Withdrawn request: req_go[0] dropped during WAIT -> transaction completes and req_done[0] pulses once.

Source files
------------

// File: rtl/mcse_bus_arbiter.sv
// mcse_bus_arbiter
// Round-robin arbiter that lets NREQ requesters share a single AHB payload
// engine. One transaction is in flight at a time. Each transaction moves
// through four states: IDLE (arbitrate), ISSUE (start pulse), WAIT (engine
// busy, timeout counting) and RESP (completion pulse to the owner).
//
// Ports
//   clk, rst          single clock; asynchronous active-high reset
//   req_go            per-requester request level
//   req_addr          packed addresses; requester i occupies slice i
//   req_write         packed write payloads; requester i occupies slice i
//   req_RW            per-requester direction (1 = write, 0 = read)
//   req_done          one-hot completion pulse to the owning requester
//   req_err           timeout flag, pulses together with req_done
//   req_rdData        read data, valid while any req_done bit is high
//   bus_go            one-cycle start pulse to the engine
//   bus_addr/write/RW transaction fields latched at grant
//   bus_done          engine completion pulse (only honoured in WAIT)
//   bus_rdData        engine read data, valid with bus_done
//   grant_id          current owner
//   busy              high whenever the FSM is not in IDLE
module mcse_bus_arbiter #(
  parameter int NREQ               = 3,
  parameter int pAHB_ADDR_WIDTH    = 32,
  parameter int pPAYLOAD_SIZE_BITS = 256,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NREQ-1:0]                      req_go,
  input  logic [NREQ*pAHB_ADDR_WIDTH-1:0]      req_addr,
  input  logic [NREQ*pPAYLOAD_SIZE_BITS-1:0]   req_write,
  input  logic [NREQ-1:0]                      req_RW,
  output logic [NREQ-1:0]                      req_done,
  output logic [NREQ-1:0]                      req_err,
  output logic [pPAYLOAD_SIZE_BITS-1:0]        req_rdData,
  output logic                                 bus_go,
  output logic [pAHB_ADDR_WIDTH-1:0]           bus_addr,
  output logic [pPAYLOAD_SIZE_BITS-1:0]        bus_write,
  output logic                                 bus_RW,
  input  logic                                 bus_done,
  input  logic [pPAYLOAD_SIZE_BITS-1:0]        bus_rdData,
  output logic [$clog2(NREQ)-1:0]              grant_id,
  output logic                                 busy
);

  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [GW-1:0]   rr_ptr;
  logic [CW-1:0]   tmo_cnt;
  logic            err_flag;
  logic            tmo_hit;
  logic            pick_valid;
  logic [GW-1:0]   pick_id;

  // Round-robin search: the first set request at or after rr_ptr wins.
  // Scanning offsets from the far end down lets the nearest hit overwrite
  // any farther one, so no priority chain needs to be built explicitly.
  // NOTE: every signal assigned in an always_comb gets a default first so
  // no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NREQ;
      if (req_go[idx]) begin
        pick_valid = 1'b1;
        pick_id    = GW'(idx);
      end
    end
  end

  assign tmo_hit = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      grant_id   <= '0;
      tmo_cnt    <= '0;
      err_flag   <= 1'b0;
      bus_addr   <= '0;
      bus_write  <= '0;
      bus_RW     <= 1'b0;
      req_rdData <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          // Transaction fields are captured once here and then held
          // untouched until the next grant.
          if (pick_valid) begin
            grant_id  <= pick_id;
            bus_addr  <= req_addr[pick_id*pAHB_ADDR_WIDTH +: pAHB_ADDR_WIDTH];
            bus_write <= req_write[pick_id*pPAYLOAD_SIZE_BITS +: pPAYLOAD_SIZE_BITS];
            bus_RW    <= req_RW[pick_id];
          end
        end
        S_ISSUE: begin
          tmo_cnt <= '0;
        end
        S_WAIT: begin
          // A completion on the same edge as the final count wins over
          // the timeout.
          if (bus_done) begin
            req_rdData <= bus_rdData;
          end else if (tmo_hit) begin
            req_rdData <= '0;
            err_flag   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        S_RESP: begin
          // The requester just served gets the lowest priority next time.
          rr_ptr   <= (grant_id == GW'(NREQ - 1)) ? '0 : grant_id + GW'(1);
          err_flag <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic. Outputs decode the registered state, so reset
  // clears them immediately without waiting for a clock.
  always_comb begin
    state_nxt = state;
    bus_go    = 1'b0;
    busy      = 1'b1;
    req_done  = '0;
    req_err   = '0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (pick_valid) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        bus_go    = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus_done || tmo_hit) state_nxt = S_RESP;
      end
      S_RESP: begin
        req_done  = NREQ'(1) << grant_id;
        if (err_flag) req_err = NREQ'(1) << grant_id;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
